// File: rtl/rotator_pipe.sv
// Pipelined barrel rotator/shifter, one mux level per stage, global-enable valid/ready.
// Define ROTATOR_PIPE_ARITH_EN to make right shifts arithmetic (sign fill); default fills with 0.
module rotator_pipe #(
  parameter int N = 8,
  localparam int L = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [L-1:0] in_rot,
  input  logic         in_dir,
  input  logic         in_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam logic [L:0]   N_W   = (L+1)'(N);
  localparam logic [L-1:0] N_LOW = L'(N);

  logic [N-1:0] data_q  [L];
  logic [L-1:0] amt_q   [L];
  logic         valid_q [L];
  logic         dir_q   [L];
  logic         shift_q [L];
  logic         fill_q  [L];

  logic         stall;
  logic         accept;
  logic         rot_ge;
  logic         in_fill;
  logic [N-1:0] norm_data;
  logic [L-1:0] norm_amt;

  // Doubled-word trick: rotate pulls wrapped bits from the copy, shift pulls fill bits.
  function automatic logic [N-1:0] step_fn(input logic [N-1:0] d, input int s,
                                           input logic dir, input logic shift,
                                           input logic fill);
    logic [2*N-1:0] w;
    if (!dir) begin
      w = shift ? {d, {N{1'b0}}} : {d, d};
      w = w << s;
      return w[2*N-1:N];
    end else begin
      w = shift ? {{N{fill}}, d} : {d, d};
      w = w >> s;
      return w[N-1:0];
    end
  endfunction

  assign stall     = valid_q[L-1] && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q[L-1];

`ifdef ROTATOR_PIPE_ARITH_EN
  logic sign_q [L];
  assign in_fill = in_dir & in_shift & in_data[N-1];
  always_comb begin
    for (int k = 0; k < L; k++) fill_q[k] = dir_q[k] & shift_q[k] & sign_q[k];
  end
`else
  assign in_fill = 1'b0;
  always_comb begin
    for (int k = 0; k < L; k++) fill_q[k] = 1'b0;
  end
`endif

  // in_rot < 2N, so a single conditional subtraction brings the amount into 0..N-1.
  always_comb begin
    rot_ge    = {1'b0, in_rot} >= N_W;
    norm_data = in_data;
    norm_amt  = in_rot;
    if (rot_ge) begin
      if (in_shift) begin
        norm_data = {N{in_fill}};
        norm_amt  = '0;
      end else begin
        norm_amt  = in_rot - N_LOW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        dir_q[k]   <= 1'b0;
        shift_q[k] <= 1'b0;
`ifdef ROTATOR_PIPE_ARITH_EN
        sign_q[k]  <= 1'b0;
`endif
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        data_q[0]  <= norm_data;
        amt_q[0]   <= norm_amt;
        dir_q[0]   <= in_dir;
        shift_q[0] <= in_shift;
`ifdef ROTATOR_PIPE_ARITH_EN
        sign_q[0]  <= in_data[N-1];
`endif
      end
      for (int k = 1; k < L; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= amt_q[k-1][L-k]
                      ? step_fn(data_q[k-1], 2**(L-k), dir_q[k-1], shift_q[k-1], fill_q[k-1])
                      : data_q[k-1];
        amt_q[k]   <= amt_q[k-1];
        dir_q[k]   <= dir_q[k-1];
        shift_q[k] <= shift_q[k-1];
`ifdef ROTATOR_PIPE_ARITH_EN
        sign_q[k]  <= sign_q[k-1];
`endif
      end
    end
  end

  // Unit step is applied on the way out of the last register, keeping latency at L.
  assign out_data = amt_q[L-1][0]
                    ? step_fn(data_q[L-1], 1, dir_q[L-1], shift_q[L-1], fill_q[L-1])
                    : data_q[L-1];

endmodule

// File: tb/tb_rotator_pipe.sv
// Directed self-checking bench for rotator_pipe: N=8 and N=6 instances.
module tb_rotator_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_dir, in_shift, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_rot;

  logic       s6_in_valid, s6_in_ready, s6_in_dir, s6_in_shift, s6_out_valid, s6_out_ready;
  logic [5:0] s6_in_data, s6_out_data;
  logic [2:0] s6_in_rot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotator_pipe #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rot(in_rot), .in_dir(in_dir), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  rotator_pipe #(.N(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(s6_in_valid), .in_ready(s6_in_ready), .in_data(s6_in_data),
    .in_rot(s6_in_rot), .in_dir(s6_in_dir), .in_shift(s6_in_shift), .out_valid(s6_out_valid),
    .out_ready(s6_out_ready), .out_data(s6_out_data));

  function automatic logic [7:0] ref8(input logic [7:0] d, input int a,
                                      input logic dir, input logic shift);
    logic [7:0] r;
    logic       fill;
`ifdef ROTATOR_PIPE_ARITH_EN
    fill = d[7];
`else
    fill = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      if (!dir) begin
        if (shift) r[i] = (i >= a) ? d[i-a] : 1'b0;
        else       r[i] = d[(i - a + 8) % 8];
      end else begin
        if (shift) r[i] = (i + a < 8) ? d[i+a] : fill;
        else       r[i] = d[(i + a) % 8];
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (s6_out_valid !== 1'b0 || s6_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_n6 got valid %b ready %b want 0 1", s6_out_valid, s6_in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] vd [8];
    int         vr [8];
    logic       vdir [8];
    logic       vsh [8];
    logic [7:0] ve [8];
    vd   = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'h3C};
    vr   = '{3, 3, 2, 2, 0, 0, 7, 5};
    vdir = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vsh  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ROTATOR_PIPE_ARITH_EN
    ve   = '{8'hA5, 8'h96, 8'hED, 8'hD0, 8'hB4, 8'hB4, 8'hFF, 8'h87};
`else
    ve   = '{8'hA5, 8'h96, 8'h2D, 8'hD0, 8'hB4, 8'hB4, 8'h01, 8'h87};
`endif
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vd[v]; in_rot = 3'(vr[v]); in_dir = vdir[v]; in_shift = vsh[v];
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== (c == 3)) begin
          errors++; $display("FAIL dir8_latency vec %0d cycle %0d got %b want %b", v, c, out_valid, (c == 3));
        end
      end
      checks++;
      if (out_data !== ve[v]) begin
        errors++; $display("FAIL dir8_data vec %0d got %h want %h", v, out_data, ve[v]);
      end
    end
  endtask

  task automatic test_n6();
    logic [5:0] vd [6];
    int         vr [6];
    logic       vdir [6];
    logic       vsh [6];
    logic [5:0] ve [6];
    vd   = '{6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23};
    vr   = '{7, 6, 0, 7, 0, 6};
    vdir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vsh  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ve   = '{6'h07, 6'h00, 6'h23, 6'h31, 6'h23, 6'h23};
    s6_out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      s6_in_valid = 1'b1; s6_in_data = vd[v]; s6_in_rot = 3'(vr[v]);
      s6_in_dir = vdir[v]; s6_in_shift = vsh[v];
      @(posedge clk);
      #1 s6_in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checks++;
        if (s6_out_valid !== (c == 3)) begin
          errors++; $display("FAIL n6_latency vec %0d cycle %0d got %b want %b", v, c, s6_out_valid, (c == 3));
        end
      end
      checks++;
      if (s6_out_data !== ve[v]) begin
        errors++; $display("FAIL n6_data vec %0d got %b want %b", v, s6_out_data, ve[v]);
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0] sd [16];
    int         sr [16];
    logic       sdir [16];
    logic       ssh [16];
    logic [7:0] se [16];
    int         got;
    int         first;
    for (int i = 0; i < 16; i++) begin
      sd[i] = 8'($urandom); sr[i] = int'($urandom_range(0, 7));
      sdir[i] = 1'($urandom); ssh[i] = 1'($urandom);
      se[i] = ref8(sd[i], sr[i], sdir[i], ssh[i]);
    end
    out_ready = 1'b1;
    got = 0;
    first = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          in_valid = 1'b1; in_data = sd[i]; in_rot = 3'(sr[i]); in_dir = sdir[i]; in_shift = ssh[i];
          @(posedge clk);
        end
        #1 in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
          @(negedge clk);
          if (out_valid) begin
            checks++;
            if (out_data !== se[got]) begin
              errors++; $display("FAIL stream_data beat %0d got %h want %h", got, out_data, se[got]);
            end
            if (first < 0) first = cyc;
            else begin
              checks++;
              if (cyc != first + got) begin
                errors++; $display("FAIL stream_gap beat %0d at cycle %0d want cycle %0d", got, cyc, first + got);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 16) begin errors++; $display("FAIL stream_count got %0d want 16", got); end
  endtask

  task automatic test_backpressure();
    logic [7:0] bd [6];
    int         br [6];
    logic       bdir [6];
    logic       bsh [6];
    logic [7:0] be [6];
    int         idx;
    int         emit;
    int         stalls;
    logic       acc;
    bd   = '{8'hB4, 8'h81, 8'h3C, 8'hF0, 8'h55, 8'h0F};
    br   = '{3, 1, 5, 4, 2, 7};
    bdir = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bsh  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) be[i] = ref8(bd[i], br[i], bdir[i], bsh[i]);
    idx = 0; emit = 0; stalls = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      if (idx < 6) begin
        in_valid = 1'b1; in_data = bd[idx]; in_rot = 3'(br[idx]); in_dir = bdir[idx]; in_shift = bsh[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", cyc, in_ready); end
        checks++;
        if (out_data !== be[emit]) begin
          errors++; $display("FAIL bp_hold_data cycle %0d got %h want %h", cyc, out_data, be[emit]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (emit >= 6) begin
          errors++; $display("FAIL bp_extra_beat cycle %0d got %h want none", cyc, out_data);
        end else if (out_data !== be[emit]) begin
          errors++; $display("FAIL bp_drain_data beat %0d got %h want %h", emit, out_data, be[emit]);
        end
        emit++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (stalls != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", stalls); end
    checks++;
    if (emit != 6 || idx != 6) begin
      errors++; $display("FAIL bp_beat_count got emitted %0d accepted %0d want 6 6", emit, idx);
    end
  endtask

  task automatic test_reset_midflight();
    int late;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB4; in_rot = 3'd3; in_dir = 1'b0; in_shift = 1'b0;
    @(posedge clk);
    #1 in_data = 8'h81; in_rot = 3'd1; in_dir = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got valid %b ready %b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    late = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL rst_ghost_beats got %0d want 0", late); end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; in_rot = 3'd5; in_dir = 1'b0; in_shift = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++; $display("FAIL rst_next_latency cycle %0d got %b want %b", c, out_valid, (c == 3));
      end
    end
    checks++;
    if (out_data !== 8'h87) begin errors++; $display("FAIL rst_next_data got %h want 87", out_data); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_rot = '0; in_dir = 1'b0; in_shift = 1'b0; out_ready = 1'b1;
    s6_in_valid = 1'b0; s6_in_data = '0; s6_in_rot = '0; s6_in_dir = 1'b0; s6_in_shift = 1'b0;
    s6_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_n6();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
